// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Owns the program counter and fetches instructions from instruction memory
// over a req/ready handshake. Each fetched instruction lands in the IF/ID
// instruction register (ir), which the control unit decodes.
//
// The block also handles:
//   - pipeline stall, using a one-entry skid buffer for data that returns
//     while the pipeline is stalled
//   - branch and jump redirects; a jump beats a branch when both arrive
//   - dropping the response of a fetch that is still in flight when a
//     redirect arrives
//
// A bubble is shown as ir = 32'h0, which the control unit decodes as NOP.
//
// Ports:
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   stall          hold ir/pc; downstream cannot accept a new instruction
//   branch_taken   redirect to branch_target
//   branch_target  branch destination byte address
//   jump           J-type redirect; takes priority over branch_taken
//   jump_index     J-type 26-bit index field
//   imem_req       instruction memory request
//   imem_addr      request address, word aligned
//   imem_ready     memory returns imem_rdata this cycle
//   imem_rdata     fetched instruction
//   ir             IF/ID instruction register
//   opcode         ir[31:26]
//   funct          ir[5:0]
//   pc_plus4       PC+4 of the instruction held in ir
//   ir_valid       ir holds a real fetched instruction
//
// States:
//   state | meaning
//   IDLE  | single cycle after reset release, nothing requested
//   FETCH | request outstanding at pc; accepts returned data
//   HOLD  | stalled with a fetched word parked in the skid buffer
//   FLUSH | redirect arrived mid-request; waiting to drop that response
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc_plus4,
    output logic        ir_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [31:0] WORD_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_AL = RESET_PC & WORD_MASK;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] pc_inc;
    logic [31:0] ir_nxt;
    logic [31:0] pc_plus4_nxt;
    logic        ir_valid_nxt;
    logic [31:0] skid;
    logic [31:0] skid_nxt;
    logic [31:0] flush_tgt;
    logic [31:0] flush_tgt_nxt;
    logic [31:0] flush_dest;

    logic        redirect;
    logic [31:0] redirect_tgt;

    // Jump target takes its upper nibble from the PC+4 of the instruction
    // currently in ir (the J-type instruction's delay-free region).
    assign redirect     = jump | branch_taken;
    assign redirect_tgt = jump ? {pc_plus4[31:28], jump_index, 2'b00}
                               : (branch_target & WORD_MASK);

    // Wraps modulo 2^32; pc is always word aligned so the sum stays aligned.
    assign pc_inc = pc + 32'd4;

    // pc is not advanced while a request is outstanding (FETCH without
    // ready, or FLUSH), so driving imem_addr straight from pc keeps the
    // address stable until the handshake completes.
    assign imem_req  = (state == FETCH) || (state == FLUSH);
    assign imem_addr = pc;

    assign opcode = ir[31:26];
    assign funct  = ir[5:0];

    // A redirect that lands on the same cycle as the dropped response wins.
    assign flush_dest = redirect ? redirect_tgt : flush_tgt;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        ir_nxt        = ir;
        pc_plus4_nxt  = pc_plus4;
        ir_valid_nxt  = ir_valid;
        skid_nxt      = skid;
        flush_tgt_nxt = flush_tgt;

        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end

            FETCH: begin
                if (redirect) begin
                    ir_nxt       = 32'h0;
                    ir_valid_nxt = 1'b0;
                    skid_nxt     = 32'h0;
                    if (imem_ready) begin
                        pc_nxt = redirect_tgt;
                    end else begin
                        flush_tgt_nxt = redirect_tgt;
                        state_nxt     = FLUSH;
                    end
                end else if (imem_ready) begin
                    pc_nxt = pc_inc;
                    if (!stall) begin
                        ir_nxt       = imem_rdata;
                        ir_valid_nxt = 1'b1;
                        pc_plus4_nxt = pc_inc;
                    end else begin
                        skid_nxt  = imem_rdata;
                        state_nxt = HOLD;
                    end
                end else if (!stall) begin
                    ir_nxt       = 32'h0;
                    ir_valid_nxt = 1'b0;
                end
            end

            HOLD: begin
                if (redirect) begin
                    ir_nxt       = 32'h0;
                    ir_valid_nxt = 1'b0;
                    skid_nxt     = 32'h0;
                    pc_nxt       = redirect_tgt;
                    state_nxt    = FETCH;
                end else if (!stall) begin
                    // pc already points past the parked word, so it is that
                    // word's PC+4.
                    ir_nxt       = skid;
                    ir_valid_nxt = 1'b1;
                    pc_plus4_nxt = pc;
                    skid_nxt     = 32'h0;
                    state_nxt    = FETCH;
                end
            end

            FLUSH: begin
                ir_nxt       = 32'h0;
                ir_valid_nxt = 1'b0;
                if (imem_ready) begin
                    pc_nxt    = flush_dest;
                    state_nxt = FETCH;
                end else begin
                    flush_tgt_nxt = flush_dest;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC_AL;
            ir        <= 32'h0;
            pc_plus4  <= 32'h0;
            ir_valid  <= 1'b0;
            skid      <= 32'h0;
            flush_tgt <= 32'h0;
        end else begin
            pc        <= pc_nxt & WORD_MASK;
            ir        <= ir_nxt;
            pc_plus4  <= pc_plus4_nxt;
            ir_valid  <= ir_valid_nxt;
            skid      <= skid_nxt;
            flush_tgt <= flush_tgt_nxt & WORD_MASK;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] ir;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc_plus4;
    logic        ir_valid;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_ir;
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [31:0] w_pc_plus4;
    logic        w_ir_valid;

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .ir            (ir),
        .opcode        (opcode),
        .funct         (funct),
        .pc_plus4      (pc_plus4),
        .ir_valid      (ir_valid)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .imem_req      (w_imem_req),
        .imem_addr     (w_imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .ir            (w_ir),
        .opcode        (w_opcode),
        .funct         (w_funct),
        .pc_plus4      (w_pc_plus4),
        .ir_valid      (w_ir_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_index    = 26'h0;
        imem_ready    = 1'b0;
        imem_rdata    = 32'h0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_ir",        ir,          32'h0);
        check("rst_valid",     ir_valid,    1'b0);
        check("rst_req",       imem_req,    1'b0);
        check("rst_addr",      imem_addr,   32'h0000_0100);
        check("rst_pc_plus4",  pc_plus4,    32'h0);
        check("rst_w_addr",    w_imem_addr, 32'hFFFF_FFFC);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_req", imem_req, 1'b0);

        // Back-to-back fetch, memory always ready
        step();
        check("f0_req",    imem_req,    1'b1);
        check("f0_addr",   imem_addr,   32'h0000_0100);
        check("f0_ir",     ir,          32'h0);
        check("w_f0_addr", w_imem_addr, 32'hFFFF_FFFC);
        imem_ready = 1'b1;
        imem_rdata = 32'h2000_0001;

        step();
        check("f1_ir",       ir,          32'h2000_0001);
        check("f1_opcode",   opcode,      6'h08);
        check("f1_funct",    funct,       6'h01);
        check("f1_pc_plus4", pc_plus4,    32'h0000_0104);
        check("f1_valid",    ir_valid,    1'b1);
        check("f1_addr",     imem_addr,   32'h0000_0104);
        check("w_wrap_addr", w_imem_addr, 32'h0000_0000);
        check("w_wrap_pp4",  w_pc_plus4,  32'h0000_0000);
        imem_rdata = 32'h2000_0002;

        step();
        check("f2_ir",       ir,        32'h2000_0002);
        check("f2_pc_plus4", pc_plus4,  32'h0000_0108);
        check("f2_addr",     imem_addr, 32'h0000_0108);

        // Fetch completes while stalled: goes to skid buffer
        stall      = 1'b1;
        imem_rdata = 32'h8C01_0004;
        step();
        check("h1_ir",   ir,        32'h2000_0002);
        check("h1_req",  imem_req,  1'b0);
        check("h1_addr", imem_addr, 32'h0000_010C);
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        step();
        check("h2_ir",  ir,       32'h2000_0002);
        check("h2_req", imem_req, 1'b0);
        step();
        check("h3_ir",    ir,       32'h2000_0002);
        check("h3_req",   imem_req, 1'b0);
        check("h3_valid", ir_valid, 1'b1);
        stall = 1'b0;
        step();
        check("h_out_ir",    ir,        32'h8C01_0004);
        check("h_out_valid", ir_valid,  1'b1);
        check("h_out_pp4",   pc_plus4,  32'h0000_010C);
        check("h_out_req",   imem_req,  1'b1);
        check("h_out_addr",  imem_addr, 32'h0000_010C);
        imem_ready = 1'b1;
        imem_rdata = 32'h2000_0004;
        step();
        check("f4_ir",   ir,        32'h2000_0004);
        check("f4_pp4",  pc_plus4,  32'h0000_0110);
        check("f4_addr", imem_addr, 32'h0000_0110);

        // Branch with ready in the same cycle: data dropped
        branch_taken  = 1'b1;
        branch_target = 32'h4000_000C;
        imem_rdata    = 32'hDEAD_BEEF;
        step();
        check("br_ir",    ir,        32'h0);
        check("br_valid", ir_valid,  1'b0);
        check("br_addr",  imem_addr, 32'h4000_000C);
        branch_taken = 1'b0;
        imem_rdata   = 32'h2000_0005;
        step();
        check("f5_ir",  ir,       32'h2000_0005);
        check("f5_pp4", pc_plus4, 32'h4000_0010);

        // Jump and branch together: jump wins
        jump          = 1'b1;
        jump_index    = 26'h000_0040;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0300;
        imem_rdata    = 32'h1111_1111;
        step();
        check("jmp_addr",  imem_addr, 32'h4000_0100);
        check("jmp_ir",    ir,        32'h0);
        check("jmp_valid", ir_valid,  1'b0);
        jump          = 1'b0;

        // Set up a pending request to 0x120
        branch_target = 32'h0000_0120;
        step();
        check("to120_addr", imem_addr, 32'h0000_0120);

        // Branch while the request is pending with ready low two cycles
        imem_ready    = 1'b0;
        branch_target = 32'h0000_0200;
        step();
        check("fl1_req",  imem_req,  1'b1);
        check("fl1_addr", imem_addr, 32'h0000_0120);
        check("fl1_ir",   ir,        32'h0);
        branch_taken = 1'b0;
        step();
        check("fl2_req",  imem_req,  1'b1);
        check("fl2_addr", imem_addr, 32'h0000_0120);
        check("fl2_ir",   ir,        32'h0);
        imem_ready = 1'b1;
        imem_rdata = 32'hBADB_AD00;
        step();
        check("fl3_addr",  imem_addr, 32'h0000_0200);
        check("fl3_ir",    ir,        32'h0);
        check("fl3_valid", ir_valid,  1'b0);
        imem_rdata = 32'h2000_0006;
        step();
        check("f6_ir",   ir,        32'h2000_0006);
        check("f6_pp4",  pc_plus4,  32'h0000_0204);
        check("f6_addr", imem_addr, 32'h0000_0204);

        // Not ready while stalled: ir held
        imem_ready = 1'b0;
        stall      = 1'b1;
        step();
        check("ns_ir",    ir,       32'h2000_0006);
        check("ns_valid", ir_valid, 1'b1);

        // Not ready, not stalled: bubble
        stall = 1'b0;
        step();
        check("bub_ir",    ir,        32'h0);
        check("bub_valid", ir_valid,  1'b0);
        check("bub_addr",  imem_addr, 32'h0000_0204);

        // Reset mid-FLUSH
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0300;
        step();
        check("pre_rst_req",  imem_req,  1'b1);
        check("pre_rst_addr", imem_addr, 32'h0000_0204);
        branch_taken = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_req",   imem_req,  1'b0);
        check("ar_addr",  imem_addr, 32'h0000_0100);
        check("ar_ir",    ir,        32'h0);
        check("ar_valid", ir_valid,  1'b0);
        check("ar_pp4",   pc_plus4,  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ar_idle_req", imem_req, 1'b0);
        step();
        check("ar_f0_req",  imem_req,  1'b1);
        check("ar_f0_addr", imem_addr, 32'h0000_0100);
        check("ar_f0_ir",   ir,        32'h0);
        imem_ready = 1'b1;
        imem_rdata = 32'h2000_0007;
        step();
        check("ar_f1_ir",    ir,        32'h2000_0007);
        check("ar_f1_pp4",   pc_plus4,  32'h0000_0104);
        check("ar_f1_valid", ir_valid,  1'b1);
        check("ar_f1_addr",  imem_addr, 32'h0000_0104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
